// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the two-requester memory port arbiter.
// No logic; state encoding and default widths only.
// Imported by the top and the wait-counter sub-module.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 15;
    localparam int DATA_W_DEF = 16;

    // Wide enough for the largest legal MAX_WAIT (255).
    localparam int WAIT_CTR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_arb_wait_ctr.sv
// Per-requester starvation counter: counts consecutive denied request cycles.
// Latency: force_o is registered-state derived, valid the cycle the count hits MAX_WAIT-1.
// Backpressure: none; clears on grant or request drop, saturates at MAX_WAIT-1.
module arb_wait_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic gnt_i,
    output logic force_o
);

    localparam logic [WAIT_CTR_W-1:0] SAT = WAIT_CTR_W'(MAX_WAIT - 1);

    logic [WAIT_CTR_W-1:0] cnt_q;
    logic [WAIT_CTR_W-1:0] cnt_d;

    // Count denied cycles, restart when served or when the request goes away.
    always_comb begin
        cnt_d = cnt_q;
        if (!req_i || gnt_i) begin
            cnt_d = '0;
        end else if (cnt_q != SAT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_o = (cnt_q == SAT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing memory read/write ports between CPU LSU (0) and debug loader (1).
// Latency: grant one cycle after a request from IDLE; read data valid one cycle after grant.
// Backpressure: requesters hold req until gnt; lock keeps ownership, starvation guard overrides lock.
// Optional build macro MEM_ARB_STATS_EN adds conflict/forced-switch statistics counters.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
`ifdef MEM_ARB_STATS_EN
    input  logic              stat_clr,
    output logic [15:0]       stat_conflicts,
    output logic [7:0]        stat_forced,
`endif
    input  logic              req0,
    input  logic              we0,
    input  logic              lock0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wen,
    output logic [15:0]       mem_waddr,
    output logic [DATA_W-1:0] mem_wdata
);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic              rr_last_q;
    logic              rvalid0_q;
    logic              rvalid1_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic              force0;
    logic              force1;

    arb_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_wait0 (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req0),
        .gnt_i   (gnt0),
        .force_o (force0)
    );

    arb_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_wait1 (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req1),
        .gnt_i   (gnt1),
        .force_o (force1)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: starvation force beats lock, lock beats alternation.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req0 && req1)   state_d = rr_last_q ? ST_OWN0 : ST_OWN1;
                else if (req0)      state_d = ST_OWN0;
                else if (req1)      state_d = ST_OWN1;
            end
            ST_OWN0: begin
                if (force1 && req1)      state_d = ST_OWN1;
                else if (req0 && lock0)  state_d = ST_OWN0;
                else if (req1)           state_d = ST_OWN1;
                else if (req0)           state_d = ST_OWN0;
                else                     state_d = ST_IDLE;
            end
            ST_OWN1: begin
                if (force0 && req0)      state_d = ST_OWN0;
                else if (req1 && lock1)  state_d = ST_OWN1;
                else if (req0)           state_d = ST_OWN0;
                else if (req1)           state_d = ST_OWN1;
                else                     state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: owner drives the memory ports; a reset cycle performs no access.
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        mem_raddr = '0;
        mem_wen   = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        case (state_q)
            ST_OWN0: begin
                gnt0      = req0 && !rst;
                mem_raddr = addr0;
                mem_waddr = 16'(addr0);
                mem_wdata = wdata0;
                mem_wen   = req0 && !rst && we0;
            end
            ST_OWN1: begin
                gnt1      = req1 && !rst;
                mem_raddr = addr1;
                mem_waddr = 16'(addr1);
                mem_wdata = wdata1;
                mem_wen   = req1 && !rst && we1;
            end
            default: ;
        endcase
    end

    // Round-robin history and registered read responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_q <= 1'b1;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            if (gnt0)      rr_last_q <= 1'b0;
            else if (gnt1) rr_last_q <= 1'b1;
            rvalid0_q <= gnt0 && !we0;
            rvalid1_q <= gnt1 && !we1;
            if (gnt0 && !we0) rdata0_q <= mem_rdata;
            if (gnt1 && !we1) rdata1_q <= mem_rdata;
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

`ifdef MEM_ARB_STATS_EN
    logic forced_evt;
    assign forced_evt = ((state_q == ST_OWN0) && force1 && req1) ||
                        ((state_q == ST_OWN1) && force0 && req0);

    // Saturating statistics: contention cycles and starvation-forced switches.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            stat_conflicts <= '0;
            stat_forced    <= '0;
        end else begin
            if (req0 && req1 && (stat_conflicts != 16'hFFFF)) stat_conflicts <= stat_conflicts + 1'b1;
            if (forced_evt && (stat_forced != 8'hFF))         stat_forced    <= stat_forced + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Table-driven bench with read-data scoreboard for mem_port_arbiter.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, lock0, req1, we1, lock1;
    logic [14:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata0, rdata1;
    logic [14:0] mem_raddr;
    logic [15:0] mem_rdata;
    logic        mem_wen;
    logic [15:0] mem_waddr;
    logic [15:0] mem_wdata;
`ifdef MEM_ARB_STATS_EN
    logic        stat_clr;
    logic [15:0] stat_conflicts;
    logic [7:0]  stat_forced;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(15), .DATA_W(16), .MAX_WAIT(8)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef MEM_ARB_STATS_EN
        .stat_clr       (stat_clr),
        .stat_conflicts (stat_conflicts),
        .stat_forced    (stat_forced),
`endif
        .req0      (req0),
        .we0       (we0),
        .lock0     (lock0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .gnt0      (gnt0),
        .rvalid0   (rvalid0),
        .rdata0    (rdata0),
        .req1      (req1),
        .we1       (we1),
        .lock1     (lock1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .gnt1      (gnt1),
        .rvalid1   (rvalid1),
        .rdata1    (rdata1),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .mem_wen   (mem_wen),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata)
    );

    // Memory model: combinational read, clocked write.
    function automatic logic [15:0] dflt(input int a);
        return (a == 'h10) ? 16'hBEEF : 16'(16'hA000 + a);
    endfunction

    logic        mem_init;
    logic [15:0] mem [0:255];
    assign mem_rdata = mem[mem_raddr[7:0]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= dflt(i);
        end else if (mem_wen) begin
            mem[mem_waddr[7:0]] <= mem_wdata;
        end
    end

    typedef struct {
        logic        req0, we0, lock0;
        logic [14:0] addr0;
        logic [15:0] wdata0;
        logic        req1, we1, lock1;
        logic [14:0] addr1;
        logic [15:0] wdata1;
        logic        egnt0, egnt1, ewen;
        logic [14:0] eraddr;
    } vec_t;

    function automatic vec_t mk(input logic r0, w0, l0, input int a0, input int d0,
                                input logic r1, w1, l1, input int a1, input int d1,
                                input logic g0, g1, wen, input int ra);
        vec_t v;
        v.req0 = r0; v.we0 = w0; v.lock0 = l0; v.addr0 = 15'(a0); v.wdata0 = 16'(d0);
        v.req1 = r1; v.we1 = w1; v.lock1 = l1; v.addr1 = 15'(a1); v.wdata1 = 16'(d1);
        v.egnt0 = g0; v.egnt1 = g1; v.ewen = wen; v.eraddr = 15'(ra);
        return v;
    endfunction

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [15:0] ref_mem [0:255];
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One clock: check last cycle's read response, drive inputs, check combinational grant.
    task automatic do_cycle(input vec_t v, input logic rst_v, input bit chk_gnt, input string tag);
        logic [15:0] e;
        bit          ev;
        @(negedge clk);
        ev = (q0.size() != 0);
        chk({tag, ":rvalid0"}, rvalid0, ev);
        if (ev) begin e = q0.pop_front(); chk({tag, ":rdata0"}, rdata0, e); end
        ev = (q1.size() != 0);
        chk({tag, ":rvalid1"}, rvalid1, ev);
        if (ev) begin e = q1.pop_front(); chk({tag, ":rdata1"}, rdata1, e); end
        rst = rst_v;
        req0 = v.req0; we0 = v.we0; lock0 = v.lock0; addr0 = v.addr0; wdata0 = v.wdata0;
        req1 = v.req1; we1 = v.we1; lock1 = v.lock1; addr1 = v.addr1; wdata1 = v.wdata1;
        #1;
        if (chk_gnt) begin
            chk({tag, ":gnt0"}, gnt0, v.egnt0);
            chk({tag, ":gnt1"}, gnt1, v.egnt1);
        end
        chk({tag, ":mem_wen"}, mem_wen, v.ewen);
        chk({tag, ":mem_raddr"}, mem_raddr, v.eraddr);
        if (!rst_v) begin
            if (v.egnt0 && !v.we0) q0.push_back(ref_mem[v.addr0[7:0]]);
            if (v.egnt0 &&  v.we0) ref_mem[v.addr0[7:0]] = v.wdata0;
            if (v.egnt1 && !v.we1) q1.push_back(ref_mem[v.addr1[7:0]]);
            if (v.egnt1 &&  v.we1) ref_mem[v.addr1[7:0]] = v.wdata1;
        end
    endtask

    vec_t tbl [12];
    vec_t idle_v;
    vec_t v;

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = dflt(i);
        rst = 1'b1; mem_init = 1'b1;
        req0 = 0; we0 = 0; lock0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; lock1 = 0; addr1 = '0; wdata1 = '0;
`ifdef MEM_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        idle_v = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0);

        //          r0 w0 l0 a0    d0       r1 w1 l1 a1    d1       g0 g1 wen raddr
        tbl[0]  = mk(1,0,0,'h10,0,         0,0,0,0,0,               0,0,0,0);
        tbl[1]  = mk(1,0,0,'h10,0,         0,0,0,0,0,               1,0,0,'h10);
        tbl[2]  = mk(0,0,0,'h10,0,         0,0,0,0,0,               0,0,0,'h10);
        tbl[3]  = mk(1,0,0,'h20,0,         1,0,0,'h21,0,            0,0,0,0);
        tbl[4]  = mk(1,0,0,'h20,0,         1,0,0,'h21,0,            0,1,0,'h21);
        tbl[5]  = mk(1,0,0,'h22,0,         1,0,0,'h23,0,            1,0,0,'h22);
        tbl[6]  = mk(1,0,0,'h24,0,         1,0,0,'h25,0,            0,1,0,'h25);
        tbl[7]  = mk(1,0,0,'h26,0,         1,0,0,'h27,0,            1,0,0,'h26);
        tbl[8]  = mk(0,0,0,0,0,            1,1,0,'hFF,'h1234,       0,1,1,'hFF);
        tbl[9]  = mk(0,0,0,0,0,            1,0,0,'hFF,0,            0,1,0,'hFF);
        tbl[10] = mk(0,0,0,0,0,            0,0,0,'hFF,0,            0,0,0,'hFF);
        tbl[11] = idle_v;

        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        chk("reset:gnt0", gnt0, 0);
        chk("reset:gnt1", gnt1, 0);
        chk("reset:rvalid0", rvalid0, 0);
        chk("reset:rvalid1", rvalid1, 0);
        chk("reset:rdata0", rdata0, 0);
        chk("reset:mem_wen", mem_wen, 0);
        chk("reset:mem_raddr", mem_raddr, 0);

        for (int i = 0; i < 12; i++) do_cycle(tbl[i], 1'b0, 1'b1, $sformatf("vec%0d", i));
`ifdef MEM_ARB_STATS_EN
        chk("stats:conflicts_contention", stat_conflicts, 5);
`endif

        // Lock held by requester 0; requester 1 must be force-granted after 8 denied cycles.
        do_cycle(mk(1,0,1,'h30,0, 0,0,0,0,0, 0,0,0,0), 1'b0, 1'b1, "lock_idle");
        do_cycle(mk(1,0,1,'h30,0, 0,0,0,0,0, 1,0,0,'h30), 1'b0, 1'b1, "lock_own_a");
        do_cycle(mk(1,0,1,'h30,0, 0,0,0,0,0, 1,0,0,'h30), 1'b0, 1'b1, "lock_own_b");
        for (int k = 0; k < 10; k++) begin
            v = mk(1,0,1,'h30,0, 1,0,0,'h31,0, (k != 8),(k == 8),0,(k == 8) ? 'h31 : 'h30);
            do_cycle(v, 1'b0, 1'b1, $sformatf("starve_k%0d", k));
        end
        do_cycle(mk(0,0,0,'h30,0, 0,0,0,0,0, 0,0,0,'h30), 1'b0, 1'b1, "release");
`ifdef MEM_ARB_STATS_EN
        chk("stats:forced", stat_forced, 1);
        chk("stats:conflicts_total", stat_conflicts, 15);
        stat_clr = 1'b1;
`endif
        do_cycle(mk(1,0,0,'h40,0, 0,0,0,0,0, 0,0,0,0), 1'b0, 1'b1, "idle_release");
`ifdef MEM_ARB_STATS_EN
        stat_clr = 1'b0;
        chk("stats:clr_conflicts", stat_conflicts, 0);
        chk("stats:clr_forced", stat_forced, 0);
`endif

        // Reset in the cycle a read is granted: no response, state back to IDLE.
        do_cycle(mk(1,0,0,'h40,0, 0,0,0,0,0, 0,0,0,'h40), 1'b1, 1'b0, "rst_read");
        do_cycle(idle_v, 1'b0, 1'b1, "after_rst_read");
        chk("after_rst_read:rdata0", rdata0, 0);

        // Reset in the cycle a write would be granted: no write reaches memory.
        do_cycle(mk(1,1,0,'h50,'h5555, 0,0,0,0,0, 0,0,0,0), 1'b0, 1'b1, "wr_idle");
        do_cycle(mk(1,1,0,'h50,'h5555, 0,0,0,0,0, 0,0,0,'h50), 1'b1, 1'b0, "rst_write");
        do_cycle(mk(1,0,0,'h50,0, 0,0,0,0,0, 0,0,0,0), 1'b0, 1'b1, "rd50_idle");
        do_cycle(mk(1,0,0,'h50,0, 0,0,0,0,0, 1,0,0,'h50), 1'b0, 1'b1, "rd50_gnt");
        do_cycle(idle_v, 1'b0, 1'b1, "rd50_resp");
        do_cycle(idle_v, 1'b0, 1'b1, "final_idle");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
